bless_router_param: RTL and testbench
=====================================

// Module: bless_router_param
// PURPOSE
//  Parametrised next-generation bufferless (BLESS) oldest-first deflection router tile.
//  Four network ports (N,E,S,W) and one local port with a valid/ready injection handshake and one ejection lane.
//  Two-cycle pipeline: route compute plus age increment, then age-ordered port allocation and registered output.
//  Supports mesh or torus, set by parameter; fields are parametric in width. Instantiated once per node in the NoC top.
// PARAMETERS
//  DATA_W   32  payload width per flit
//  XW       2   x-coordinate width
//  YW       2   y-coordinate width
//  AGE_W    8   age field width; saturating counter
//  ADDR_X   1   this node's x coordinate
//  ADDR_Y   1   this node's y coordinate
//  MAX_X    3   largest x coordinate in the network
//  MAX_Y    3   largest y coordinate in the network
//  TORUS    0   0 = mesh, 1 = torus with wrap links
//  FLIT_W   derived: 1+XW+YW+AGE_W+DATA_W; fields {valid,dst_x,dst_y,age,data}, valid is the MSB
// PORTS
//  clk        in   1         clock; all state updates on the rising edge
//  rst        in   1         asynchronous, active-high reset
//  net_in     in   4*FLIT_W  flits from neighbours; slice p = port p (0=N y-1, 1=E x+1, 2=S y+1, 3=W x-1)
//  net_out    out  4*FLIT_W  flits to neighbours; same slice order
//  inj_flit   in   FLIT_W    local injection flit; its valid bit is ignored
//  inj_valid  in   1         local port offers a flit
//  inj_ready  out  1         combinational; inj_valid & inj_ready = flit accepted this cycle
//  ej_flit    out  FLIT_W    ejected flit
//  ej_valid   out  1         ej_flit valid
// BEHAVIOUR
//  Reset: net_out, ej_flit and all pipeline registers clear to 0 asynchronously, so every valid bit is 0.
//   A reset mid-operation drops in-flight flits; there is no recovery. inj_ready reads 1 while rst is high.
//  inj_ready = (count of valid net_in) < 4. On acceptance, the flit enters the local slot with age forced to 0.
//  Stage 1 (edge k): register the four net_in slices and the local slot.
//   - Age of valid network flits = min(age+1, 2^AGE_W-1).
//   - Route compute: per flit, a productive-port mask (bit per N,E,S,W) or LOCAL if dst matches (ADDR_X,ADDR_Y).
//   - Mesh: the x-direction bit is set if dst_x != ADDR_X; the y-direction bit is set if dst_y != ADDR_Y.
//   - Torus: pick the shorter direction per dimension, using modulo MAX+1 distance; on a tie, pick the positive direction (E or S).
//  Stage 2 (edge k+1): allocate ports and register the results.
//   - Priority: higher age first; ties go to the lower input index; the local slot is index 4.
//   - Ejection: the highest-priority valid LOCAL flit goes to ej_flit. Other LOCAL flits are deflected like the rest.
//   - In priority order, each remaining flit takes the first free productive port, x-direction before y.
//   - If no productive port is free, the flit takes the first free port in order N,E,S,W. It is never dropped.
//   - Invalid slots allocate nothing. Unused outputs drive all-zero flits.
//  Latency: net_in to net_out/ej is exactly 2 cycles, whether the flit is deflected or not. inj to out is also 2 cycles.
//  Conservation: the inj_ready rule guarantees at most 4 non-ejected flits; the allocator asserts in sim when this is violated.
//  Edge ports of a mesh (e.g. N at y=0) stay allocatable. Edge nodes must tie unused net_in to 0.
//   Deflection onto an edge port is still legal in the model; the NoC top reflects it.
//  Data and dst fields pass unmodified. Only age is rewritten.
// STRUCTURE
//  Shared package bless_pkg:
//   - flit field offsets and widths as functions of the parameters
//   - port index constants P_N=0, P_E=1, P_S=2, P_W=3, P_L=4
//   - a route-mask typedef
//  Sub-module bless_route_compute: combinational, one instance per slot (5 total); takes dst, outputs a 5-bit mask.
//  Stage-2 allocator: an unrolled priority-sort plus greedy grant loop inside this module.
// TESTING
//  1. Reset: assert rst async mid-cycle with 4 flits in flight -> all outputs invalid immediately; inj_ready=1.
//  2. Mesh, node (1,1), E input dst (3,1) age 5 -> W... no: goes E; net_out slice 1 valid two cycles later with age 6.
//  3. Conflict: N and S inputs both dst (2,1), ages 9 and 4 -> age-10 flit on E; age-5 flit deflected to N (first free).
//  4. Full load: 4 valid inputs, inj_valid=1 -> inj_ready=0; the next cycle with 3 inputs -> accepted, output age 0, 2-cycle latency.
//  5. Two local-destined flits, ages 7 and 7 on ports 1 and 3 -> port-1 flit ejected; port-3 flit deflected to N.
//  6. TORUS=1, MAX_X=3, node x=0, dst_x=3 -> W chosen; dst_x=2 (tie) -> E chosen; age 255 saturates at 255.

Source files
------------

// File: rtl/bless_pkg.sv
`default_nettype none
// ============================================================================
// bless_pkg : shared flit layout helpers, port indices and route-mask type
// Rev 1.0
// ============================================================================
package bless_pkg;

   localparam int P_N = 0;
   localparam int P_E = 1;
   localparam int P_S = 2;
   localparam int P_W = 3;
   localparam int P_L = 4;
   localparam int NUM_NET   = 4;
   localparam int NUM_SLOTS = 5;

   typedef logic [NUM_SLOTS-1:0] route_mask_t;

   // Flit layout, MSB first: {valid, dst_x, dst_y, age, data}
   function automatic int flit_w(int data_w, int xw, int yw, int age_w);
      return 1 + xw + yw + age_w + data_w;
   endfunction

   function automatic int age_lsb(int data_w);
      return data_w;
   endfunction

   function automatic int dy_lsb(int data_w, int age_w);
      return data_w + age_w;
   endfunction

   function automatic int dx_lsb(int data_w, int age_w, int yw);
      return data_w + age_w + yw;
   endfunction

   // Productive-port search order: x-direction ports before y-direction ports
   function automatic int x_first_port(int k);
      case (k)
         0:       return P_E;
         1:       return P_W;
         2:       return P_S;
         default: return P_N;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/bless_route_compute.sv
`default_nettype none
// ============================================================================
// bless_route_compute : productive-port mask (N,E,S,W,LOCAL) for one flit
// Rev 1.0
// ============================================================================
module bless_route_compute
   import bless_pkg::*;
#(
   parameter int XW     = 2,
   parameter int YW     = 2,
   parameter int ADDR_X = 1,
   parameter int ADDR_Y = 1,
   parameter int MAX_X  = 3,
   parameter int MAX_Y  = 3,
   parameter int TORUS  = 0
)(
   input  logic [XW-1:0] dst_x,
   input  logic [YW-1:0] dst_y,
   output route_mask_t   mask
);

   localparam int RING_X = MAX_X + 1;
   localparam int RING_Y = MAX_Y + 1;

   int dx;
   int dy;
   int dx_fwd;
   int dy_fwd;

   always_comb begin
      mask   = '0;
      dx     = int'(dst_x);
      dy     = int'(dst_y);
      // Hop count travelling in the positive direction around each ring
      dx_fwd = (dx >= ADDR_X) ? (dx - ADDR_X) : (dx + RING_X - ADDR_X);
      dy_fwd = (dy >= ADDR_Y) ? (dy - ADDR_Y) : (dy + RING_Y - ADDR_Y);
      if (dx == ADDR_X && dy == ADDR_Y) begin
         mask[P_L] = 1'b1;
      end else if (TORUS != 0) begin
         if (dx_fwd != 0) begin
            if (dx_fwd <= RING_X - dx_fwd) mask[P_E] = 1'b1;
            else                           mask[P_W] = 1'b1;
         end
         if (dy_fwd != 0) begin
            if (dy_fwd <= RING_Y - dy_fwd) mask[P_S] = 1'b1;
            else                           mask[P_N] = 1'b1;
         end
      end else begin
         if (dx > ADDR_X)      mask[P_E] = 1'b1;
         else if (dx < ADDR_X) mask[P_W] = 1'b1;
         if (dy > ADDR_Y)      mask[P_S] = 1'b1;
         else if (dy < ADDR_Y) mask[P_N] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bless_router_param.sv
`default_nettype none
// ============================================================================
// bless_router_param : two-stage oldest-first bufferless deflection router
// Rev 1.0
// ============================================================================
module bless_router_param
   import bless_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int XW     = 2,
   parameter int YW     = 2,
   parameter int AGE_W  = 8,
   parameter int ADDR_X = 1,
   parameter int ADDR_Y = 1,
   parameter int MAX_X  = 3,
   parameter int MAX_Y  = 3,
   parameter int TORUS  = 0,
   localparam int FLIT_W = flit_w(DATA_W, XW, YW, AGE_W)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*FLIT_W-1:0]     net_in,
   output logic [4*FLIT_W-1:0]     net_out,
   input  logic [FLIT_W-1:0]       inj_flit,
   input  logic                    inj_valid,
   output logic                    inj_ready,
   output logic [FLIT_W-1:0]       ej_flit,
   output logic                    ej_valid
);

   localparam int AGE_LSB   = age_lsb(DATA_W);
   localparam int DY_LSB    = dy_lsb(DATA_W, AGE_W);
   localparam int DX_LSB    = dx_lsb(DATA_W, AGE_W, YW);
   localparam int VALID_BIT = FLIT_W - 1;

   logic [FLIT_W-1:0] in_flit     [NUM_NET];
   logic [2:0]        in_count;
   logic              inj_accept;
   logic [FLIT_W-1:0] s1_next     [NUM_SLOTS];
   route_mask_t       s1_mask_next[NUM_SLOTS];
   logic [FLIT_W-1:0] s1_flit     [NUM_SLOTS];
   route_mask_t       s1_mask     [NUM_SLOTS];

   logic [NUM_SLOTS-1:0] slot_valid;
   logic [AGE_W-1:0]     slot_age  [NUM_SLOTS];
   logic [2:0]           rank      [NUM_SLOTS];
   logic [FLIT_W-1:0]    out_next  [NUM_NET];
   logic [FLIT_W-1:0]    ej_next;
   logic                 ej_taken;
   logic [NUM_NET-1:0]   busy;
   logic                 placed;
   logic                 found;
   logic [2:0]           sel;
   int                   port;
   logic                 alloc_overflow;

   generate
      for (genvar p = 0; p < NUM_NET; p++) begin : g_unpack
         assign in_flit[p] = net_in[p*FLIT_W +: FLIT_W];
      end
   endgenerate

   always_comb begin
      in_count = '0;
      for (int p = 0; p < NUM_NET; p++)
         in_count = in_count + {2'b00, in_flit[p][VALID_BIT]};
   end

   assign inj_ready  = rst | (in_count != 3'd4);
   assign inj_accept = inj_valid & inj_ready;

   // Stage 1: saturating age increment and local-slot capture
   always_comb begin
      for (int p = 0; p < NUM_NET; p++) begin
         s1_next[p] = '0;
         if (in_flit[p][VALID_BIT]) begin
            s1_next[p] = in_flit[p];
            if (in_flit[p][AGE_LSB +: AGE_W] != {AGE_W{1'b1}})
               s1_next[p][AGE_LSB +: AGE_W] = in_flit[p][AGE_LSB +: AGE_W] + AGE_W'(1);
         end
      end
      s1_next[P_L] = '0;
      if (inj_accept) begin
         s1_next[P_L]                   = inj_flit;
         s1_next[P_L][VALID_BIT]        = 1'b1;
         s1_next[P_L][AGE_LSB +: AGE_W] = '0;
      end
   end

   generate
      for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_route
         bless_route_compute #(
            .XW     (XW),
            .YW     (YW),
            .ADDR_X (ADDR_X),
            .ADDR_Y (ADDR_Y),
            .MAX_X  (MAX_X),
            .MAX_Y  (MAX_Y),
            .TORUS  (TORUS)
         ) u_route (
            .dst_x (s1_next[s][DX_LSB +: XW]),
            .dst_y (s1_next[s][DY_LSB +: YW]),
            .mask  (s1_mask_next[s])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            s1_flit[s] <= '0;
            s1_mask[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            s1_flit[s] <= s1_next[s];
            s1_mask[s] <= s1_mask_next[s];
         end
      end
   end

   // Priority rank: number of valid slots that beat this one (older, or same age and lower index)
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_valid[i] = s1_flit[i][VALID_BIT];
         slot_age[i]   = s1_flit[i][AGE_LSB +: AGE_W];
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         rank[i] = '0;
         for (int j = 0; j < NUM_SLOTS; j++) begin
            if (j != i && slot_valid[j] &&
                (slot_age[j] > slot_age[i] || (slot_age[j] == slot_age[i] && j < i)))
               rank[i] = rank[i] + 3'd1;
         end
      end
   end

   // Stage 2: greedy grant in rank order -- eject, productive port, then first free port
   always_comb begin
      busy           = '0;
      ej_taken       = 1'b0;
      ej_next        = '0;
      alloc_overflow = 1'b0;
      placed         = 1'b0;
      found          = 1'b0;
      sel            = '0;
      port           = 0;
      for (int p = 0; p < NUM_NET; p++)
         out_next[p] = '0;
      for (int r = 0; r < NUM_SLOTS; r++) begin
         found = 1'b0;
         sel   = '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_valid[i] && rank[i] == 3'(r)) begin
               found = 1'b1;
               sel   = 3'(i);
            end
         end
         placed = 1'b0;
         if (found && s1_mask[sel][P_L] && !ej_taken) begin
            ej_next  = s1_flit[sel];
            ej_taken = 1'b1;
            placed   = 1'b1;
         end
         for (int k = 0; k < NUM_NET; k++) begin
            port = x_first_port(k);
            if (found && !placed && s1_mask[sel][port] && !busy[port]) begin
               out_next[port] = s1_flit[sel];
               busy[port]     = 1'b1;
               placed         = 1'b1;
            end
         end
         for (int p = 0; p < NUM_NET; p++) begin
            if (found && !placed && !busy[p]) begin
               out_next[p] = s1_flit[sel];
               busy[p]     = 1'b1;
               placed      = 1'b1;
            end
         end
         if (found && !placed)
            alloc_overflow = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         net_out  <= '0;
         ej_flit  <= '0;
         ej_valid <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_NET; p++)
            net_out[p*FLIT_W +: FLIT_W] <= out_next[p];
         ej_flit  <= ej_next;
         ej_valid <= ej_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         assert (!alloc_overflow);
   end

endmodule
`default_nettype wire

// File: tb/tb_bless_router_param.sv
`default_nettype none
// ============================================================================
// tb_bless_router_param : scoreboard bench, mesh node (1,1) and torus node (0,1)
// Rev 1.0
// ============================================================================
module tb_bless_router_param;

   localparam int DW   = 32;
   localparam int FW   = 45;
   localparam int RING = 4;

   typedef struct {
      int              due;
      logic [4*FW-1:0] nout;
      logic [FW-1:0]   ej;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [4*FW-1:0] net_in_m = '0, net_in_t = '0;
   logic [4*FW-1:0] net_out_m, net_out_t;
   logic [FW-1:0]   inj_flit_m = '0, inj_flit_t = '0;
   logic            inj_valid_m = 1'b0, inj_valid_t = 1'b0;
   logic            inj_ready_m, inj_ready_t;
   logic [FW-1:0]   ej_flit_m, ej_flit_t;
   logic            ej_valid_m, ej_valid_t;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q_m[$];
   exp_t q_t[$];

   bless_router_param #(.ADDR_X(1), .ADDR_Y(1), .TORUS(0)) u_mesh (
      .clk(clk), .rst(rst), .net_in(net_in_m), .net_out(net_out_m),
      .inj_flit(inj_flit_m), .inj_valid(inj_valid_m), .inj_ready(inj_ready_m),
      .ej_flit(ej_flit_m), .ej_valid(ej_valid_m));

   bless_router_param #(.ADDR_X(0), .ADDR_Y(1), .TORUS(1)) u_torus (
      .clk(clk), .rst(rst), .net_in(net_in_t), .net_out(net_out_t),
      .inj_flit(inj_flit_t), .inj_valid(inj_valid_t), .inj_ready(inj_ready_t),
      .ej_flit(ej_flit_t), .ej_valid(ej_valid_t));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [FW-1:0] mk(bit v, int dx, int dy, int age, logic [DW-1:0] d);
      return {v, 2'(dx), 2'(dy), 8'(age), d};
   endfunction

   function automatic logic [4*FW-1:0] pack4(logic [FW-1:0] f0, logic [FW-1:0] f1,
                                             logic [FW-1:0] f2, logic [FW-1:0] f3);
      return {f3, f2, f1, f0};
   endfunction

   // Direction toward destination along one dimension, or -1 if already aligned
   function automatic int dir(int d, int a, bit tor, int pos_port, int neg_port);
      int fwd;
      if (d == a) return -1;
      if (tor) begin
         fwd = (((d - a) % RING) + RING) % RING;
         return (fwd <= RING - fwd) ? pos_port : neg_port;
      end
      return (d > a) ? pos_port : neg_port;
   endfunction

   task automatic model(input logic [4*FW-1:0] nin, input logic [FW-1:0] inj, input bit acc,
                        input int ax, input int ay, input bit tor,
                        output logic [4*FW-1:0] nout, output logic [FW-1:0] ej);
      logic [FW-1:0] f [5];
      bit has [5];
      bit done [5];
      bit used [4];
      bit ejd, put;
      int best, bestkey, key, dx, dy, xd, yd;
      int prefs[$];
      nout = '0;
      ej   = '0;
      ejd  = 1'b0;
      for (int p = 0; p < 4; p++) begin
         f[p]   = nin[p*FW +: FW];
         has[p] = f[p][FW-1];
         if (has[p] && f[p][39:32] != 8'd255) f[p][39:32] = f[p][39:32] + 8'd1;
         used[p] = 1'b0;
      end
      f[4] = inj;
      f[4][FW-1] = 1'b1;
      f[4][39:32] = 8'd0;
      has[4] = acc;
      for (int i = 0; i < 5; i++) done[i] = 1'b0;
      for (int n = 0; n < 5; n++) begin
         best = -1;
         bestkey = -1;
         for (int i = 0; i < 5; i++) begin
            key = int'(f[i][39:32]) * 8 + (7 - i);
            if (has[i] && !done[i] && key > bestkey) begin
               bestkey = key;
               best = i;
            end
         end
         if (best >= 0) begin
            done[best] = 1'b1;
            dx = int'(f[best][43:42]);
            dy = int'(f[best][41:40]);
            if (dx == ax && dy == ay && !ejd) begin
               ej  = f[best];
               ejd = 1'b1;
            end else begin
               prefs.delete();
               xd = dir(dx, ax, tor, 1, 3);
               yd = dir(dy, ay, tor, 2, 0);
               if (xd >= 0) prefs.push_back(xd);
               if (yd >= 0) prefs.push_back(yd);
               for (int p = 0; p < 4; p++) prefs.push_back(p);
               put = 1'b0;
               foreach (prefs[k]) begin
                  if (!put && !used[prefs[k]]) begin
                     used[prefs[k]] = 1'b1;
                     nout[prefs[k]*FW +: FW] = f[best];
                     put = 1'b1;
                  end
               end
            end
         end
      end
   endtask

   function automatic int nvalid(logic [4*FW-1:0] v);
      int c = 0;
      for (int p = 0; p < 4; p++) c += int'(v[p*FW + FW - 1]);
      return c;
   endfunction

   task automatic drive(input logic [4*FW-1:0] nm, input logic [FW-1:0] im, input bit vm,
                        input logic [4*FW-1:0] nt, input logic [FW-1:0] it, input bit vt);
      exp_t e;
      logic [4*FW-1:0] no;
      logic [FW-1:0] ej;
      bit want_m, want_t;
      @(posedge clk);
      #2;
      net_in_m = nm; inj_flit_m = im; inj_valid_m = vm;
      net_in_t = nt; inj_flit_t = it; inj_valid_t = vt;
      #1;
      want_m = (nvalid(nm) < 4);
      want_t = (nvalid(nt) < 4);
      checks++;
      if (inj_ready_m !== want_m) begin
         errors++;
         $display("FAIL mesh inj_ready: got %b expected %b", inj_ready_m, want_m);
      end
      checks++;
      if (inj_ready_t !== want_t) begin
         errors++;
         $display("FAIL torus inj_ready: got %b expected %b", inj_ready_t, want_t);
      end
      model(nm, im, vm && want_m, 1, 1, 1'b0, no, ej);
      e.due = cyc + 2; e.nout = no; e.ej = ej;
      q_m.push_back(e);
      model(nt, it, vt && want_t, 0, 1, 1'b1, no, ej);
      e.due = cyc + 2; e.nout = no; e.ej = ej;
      q_t.push_back(e);
   endtask

   function automatic logic [FW-1:0] rnd_flit(bit v);
      int age;
      age = ($urandom_range(0, 7) == 0) ? $urandom_range(254, 255) : $urandom_range(0, 255);
      return mk(v, $urandom_range(0, 3), $urandom_range(0, 3), age, $urandom);
   endfunction

   function automatic logic [4*FW-1:0] rnd_net();
      logic [4*FW-1:0] v = '0;
      for (int p = 0; p < 4; p++)
         if ($urandom_range(0, 1) == 1) v[p*FW +: FW] = rnd_flit(1'b1);
      return v;
   endfunction

   // Monitor: compares whatever the DUT presents against the due scoreboard entry
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (q_m.size() > 0 && q_m[0].due == cyc) begin
            e = q_m.pop_front();
            for (int p = 0; p < 4; p++) begin
               checks++;
               if (net_out_m[p*FW +: FW] !== e.nout[p*FW +: FW]) begin
                  errors++;
                  $display("FAIL mesh net_out[%0d] cyc %0d: got %h expected %h", p, cyc,
                           net_out_m[p*FW +: FW], e.nout[p*FW +: FW]);
               end
            end
            checks++;
            if ({ej_valid_m, ej_flit_m} !== {e.ej[FW-1], e.ej}) begin
               errors++;
               $display("FAIL mesh ej cyc %0d: got %b/%h expected %b/%h", cyc,
                        ej_valid_m, ej_flit_m, e.ej[FW-1], e.ej);
            end
         end
         if (q_t.size() > 0 && q_t[0].due == cyc) begin
            e = q_t.pop_front();
            for (int p = 0; p < 4; p++) begin
               checks++;
               if (net_out_t[p*FW +: FW] !== e.nout[p*FW +: FW]) begin
                  errors++;
                  $display("FAIL torus net_out[%0d] cyc %0d: got %h expected %h", p, cyc,
                           net_out_t[p*FW +: FW], e.nout[p*FW +: FW]);
               end
            end
            checks++;
            if ({ej_valid_t, ej_flit_t} !== {e.ej[FW-1], e.ej}) begin
               errors++;
               $display("FAIL torus ej cyc %0d: got %b/%h expected %b/%h", cyc,
                        ej_valid_t, ej_flit_t, e.ej[FW-1], e.ej);
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      checks++;
      if (net_out_m !== '0 || ej_flit_m !== '0 || ej_valid_m !== 1'b0 || inj_ready_m !== 1'b1) begin
         errors++;
         $display("FAIL %s mesh: got out=%h ej=%b inj_ready=%b expected zeros, inj_ready=1",
                  tag, net_out_m, ej_valid_m, inj_ready_m);
      end
      checks++;
      if (net_out_t !== '0 || ej_flit_t !== '0 || ej_valid_t !== 1'b0 || inj_ready_t !== 1'b1) begin
         errors++;
         $display("FAIL %s torus: got out=%h ej=%b inj_ready=%b expected zeros, inj_ready=1",
                  tag, net_out_t, ej_valid_t, inj_ready_t);
      end
   endtask

   initial begin
      logic [4*FW-1:0] z4;
      logic [4*FW-1:0] full;
      z4 = '0;
      #12;
      check_reset_state("reset_initial");
      @(posedge clk); #3; rst = 1'b0;

      // Directed mesh cases at node (1,1)
      drive(pack4('0, mk(1, 3, 1, 5, 32'hE0E0_0002), '0, '0), '0, 1'b0, z4, '0, 1'b0);
      drive(pack4(mk(1, 2, 1, 9, 32'hA5A5_0009), '0, mk(1, 2, 1, 4, 32'h5A5A_0004), '0),
            '0, 1'b0, z4, '0, 1'b0);
      full = pack4(mk(1, 0, 0, 3, 32'h1), mk(1, 3, 3, 2, 32'h2), mk(1, 1, 0, 1, 32'h3),
                   mk(1, 2, 2, 0, 32'h4));
      drive(full, mk(1, 2, 2, 77, 32'hDEAD_0001), 1'b1, z4, '0, 1'b0);
      drive(pack4(mk(1, 0, 0, 3, 32'h5), mk(1, 3, 3, 2, 32'h6), '0, mk(1, 1, 2, 0, 32'h7)),
            mk(0, 2, 2, 77, 32'hBEEF_0002), 1'b1, z4, '0, 1'b0);
      drive(pack4('0, mk(1, 1, 1, 7, 32'h0000_0011), '0, mk(1, 1, 1, 7, 32'h0000_0033)),
            '0, 1'b0, z4, '0, 1'b0);

      // Directed torus cases at node (0,1): wrap west, tie east, age saturation
      drive(z4, '0, 1'b0,
            pack4(mk(1, 3, 1, 255, 32'h7070_0003), '0, mk(1, 2, 1, 3, 32'h7070_0002), '0),
            '0, 1'b0);
      drive(z4, '0, 1'b0, pack4('0, '0, '0, mk(1, 2, 1, 10, 32'h7070_0012)), '0, 1'b0);

      for (int n = 0; n < 300; n++)
         drive(rnd_net(), rnd_flit($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
               rnd_net(), rnd_flit($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);

      // Asynchronous reset mid-cycle with four flits in flight
      full = pack4(rnd_flit(1'b1), rnd_flit(1'b1), rnd_flit(1'b1), rnd_flit(1'b1));
      drive(full, rnd_flit(1'b1), 1'b1, full, rnd_flit(1'b1), 1'b1);
      drive(full, rnd_flit(1'b1), 1'b1, full, rnd_flit(1'b1), 1'b1);
      @(posedge clk); #3;
      rst = 1'b1;
      q_m.delete();
      q_t.delete();
      #1;
      check_reset_state("reset_midop");
      @(posedge clk); #3;
      net_in_m = '0; net_in_t = '0; inj_valid_m = 1'b0; inj_valid_t = 1'b0;
      rst = 1'b0;

      for (int n = 0; n < 40; n++)
         drive(rnd_net(), rnd_flit(1'b0), $urandom_range(0, 1) == 1,
               rnd_net(), rnd_flit(1'b0), $urandom_range(0, 1) == 1);
      for (int n = 0; n < 3; n++)
         drive(z4, '0, 1'b0, z4, '0, 1'b0);
      repeat (4) @(posedge clk);
      #3;
      checks++;
      if (q_m.size() != 0 || q_t.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q_m.size(), q_t.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
